// File: rtl/sc130gs_i2c_cfg_writer_pkg.sv
// Shared types and constants for the SC130GS register-configuration I2C writer.
// Holds the sequencer states, quarter-bit phase codes and LUT word field positions.
package sc130gs_cfg_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_PON,
    ST_LOAD,
    ST_START,
    ST_BYTE,
    ST_ACK,
    ST_STOP,
    ST_GAP,
    ST_DONE
  } cfg_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int BYTES_PER_WRITE = 4;

  // LUT word layout: {reg_addr[15:0], data[7:0]}
  localparam int REG_ADDR_MSB = 23;
  localparam int REG_ADDR_LSB = 8;
  localparam int DATA_MSB     = 7;
  localparam int DATA_LSB     = 0;

  function automatic logic [7:0] write_byte(input logic [1:0] idx,
                                            input logic [7:0] waddr,
                                            input logic [23:0] word);
    logic [7:0] b;
    case (idx)
      2'd0:    b = waddr;
      2'd1:    b = word[REG_ADDR_MSB -: 8];
      2'd2:    b = word[REG_ADDR_LSB + 7 -: 8];
      default: b = word[DATA_MSB : DATA_LSB];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sc130gs_i2c_cfg_writer_qtick.sv
// Quarter-bit tick divider for the I2C writer: one-clk pulse every QDIV clks while enabled.
// Held at its reload value whenever disabled or cleared so each bus phase starts full length.
module i2c_qtick_gen #(
  parameter int QDIV = 62
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(QDIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr || !en)
      cnt_q <= RELOAD;
    else if (cnt_q == '0)
      cnt_q <= RELOAD;
    else
      cnt_q <= cnt_q - 1'b1;
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/sc130gs_i2c_cfg_writer.sv
// Walks the SC130GS configuration LUT and writes each entry over I2C
// (dev addr, reg addr MSB/LSB, data), with NACK retry and settle delays.
//
// state    | meaning
// WAIT_PON | power-up settle delay after reset
// LOAD     | latch current LUT word, reset byte counter
// START    | START condition bit
// BYTE     | shift out 8 bits MSB first
// ACK      | release SDA, sample slave acknowledge
// STOP     | STOP condition bit
// GAP      | post-write settle, then retry/advance decision
// DONE     | all entries processed, bus idle
module sc130gs_i2c_cfg_writer
  import sc130gs_cfg_pkg::*;
#(
  parameter int         CLK_FREQ    = 25_000_000,
  parameter int         I2C_FREQ    = 100_000,
  parameter logic [7:0] I2C_WADDR   = 8'h60,
  parameter int         POWERON_DLY = 250_000,
  parameter int         REG_GAP     = 1000,
  parameter int         RETRY_MAX   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [8:0]  i2c_config_index,
  input  logic [23:0] i2c_config_data,
  input  logic [8:0]  i2c_config_size,
  output logic        i2c_config_done,
  output logic        i2c_ack_err,
  output logic [7:0]  i2c_err_cnt,
  output logic        i2c_sclk,
  inout  wire         i2c_sdat
);

  localparam int QDIV    = CLK_FREQ / (4 * I2C_FREQ);
  localparam int DLY_MAX = (POWERON_DLY > REG_GAP) ? POWERON_DLY : REG_GAP;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam logic [DLY_W-1:0] PON_LOAD   = DLY_W'(POWERON_DLY - 1);
  localparam logic [DLY_W-1:0] GAP_LOAD   = DLY_W'(REG_GAP - 1);
  localparam logic [7:0]       RETRY_LAST = 8'(RETRY_MAX - 1);
  localparam logic [1:0]       LAST_BYTE  = 2'(BYTES_PER_WRITE - 1);

  cfg_state_e       state_q, state_d;
  logic [1:0]       phase_q;
  logic [2:0]       bit_cnt_q;
  logic [1:0]       byte_cnt_q;
  logic [7:0]       shreg_q;
  logic [23:0]      word_q;
  logic             nack_q;
  logic             ok_q;
  logic [7:0]       retry_q;
  logic [DLY_W-1:0] dly_q;
  logic [8:0]       idx_q;
  logic             ack_err_q;
  logic [7:0]       err_cnt_q;
  logic             scl_q, sda_oe_q, done_q;

  logic qtick, bit_end, bus_active;
  logic give_up, advance, seq_end;
  logic [8:0] idx_next;
  logic scl_d, sda_low_d;

  assign bus_active = (state_q == ST_START) || (state_q == ST_BYTE) ||
                      (state_q == ST_ACK)   || (state_q == ST_STOP);

  i2c_qtick_gen #(.QDIV(QDIV)) u_qtick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus_active),
    .clr   (state_q == ST_LOAD),
    .tick  (qtick)
  );

  assign bit_end = qtick && (phase_q == Q3);

  // Retry/advance decision taken when the post-write gap expires
  assign give_up  = !ok_q && (retry_q >= RETRY_LAST);
  assign advance  = ok_q || give_up;
  assign idx_next = advance ? idx_q + 9'd1 : idx_q;
  assign seq_end  = idx_next >= i2c_config_size;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_WAIT_PON;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_PON: if (dly_q == '0) state_d = (i2c_config_size == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD:     state_d = ST_START;
      ST_START:    if (bit_end) state_d = ST_BYTE;
      ST_BYTE:     if (bit_end && bit_cnt_q == 3'd7) state_d = ST_ACK;
      ST_ACK:      if (bit_end) state_d = (nack_q || byte_cnt_q == LAST_BYTE) ? ST_STOP : ST_BYTE;
      ST_STOP:     if (bit_end) state_d = ST_GAP;
      ST_GAP:      if (dly_q == '0) state_d = seq_end ? ST_DONE : ST_LOAD;
      default:     state_d = ST_DONE;
    endcase
  end

  always_comb begin
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    case (state_q)
      ST_START: begin
        scl_d     = (phase_q != Q3);
        sda_low_d = (phase_q != Q0);
      end
      ST_BYTE: begin
        scl_d     = phase_q[1];
        sda_low_d = !shreg_q[7];
      end
      ST_ACK:  scl_d = phase_q[1];
      ST_STOP: begin
        scl_d     = phase_q[1];
        sda_low_d = (phase_q != Q3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      scl_q    <= scl_d;
      sda_oe_q <= sda_low_d;
      done_q   <= (state_q == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q    <= Q0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      word_q     <= '0;
      nack_q     <= 1'b1;
      ok_q       <= 1'b0;
      retry_q    <= '0;
      dly_q      <= PON_LOAD;
      idx_q      <= '0;
      ack_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (state_q == ST_LOAD) phase_q <= Q0;
      else if (qtick)         phase_q <= phase_q + 2'd1;

      case (state_q)
        ST_WAIT_PON: if (dly_q != '0) dly_q <= dly_q - 1'b1;
        ST_LOAD: begin
          word_q     <= i2c_config_data;
          byte_cnt_q <= '0;
          bit_cnt_q  <= '0;
        end
        ST_START: if (bit_end) shreg_q <= write_byte(2'd0, I2C_WADDR, word_q);
        ST_BYTE: if (bit_end) begin
          shreg_q   <= {shreg_q[6:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        ST_ACK: begin
          if (qtick && phase_q == Q2) nack_q <= i2c_sdat;
          if (bit_end) begin
            ok_q <= !nack_q && (byte_cnt_q == LAST_BYTE);
            if (!nack_q && byte_cnt_q != LAST_BYTE) begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
              shreg_q    <= write_byte(byte_cnt_q + 2'd1, I2C_WADDR, word_q);
            end
          end
        end
        // The soft-reset entry needs the full power-up settle before the next write
        ST_STOP: if (bit_end) dly_q <= (ok_q && idx_q == '0) ? PON_LOAD : GAP_LOAD;
        ST_GAP: begin
          if (dly_q != '0) begin
            dly_q <= dly_q - 1'b1;
          end else begin
            idx_q <= idx_next;
            if (ok_q) begin
              retry_q <= '0;
            end else if (give_up) begin
              retry_q   <= '0;
              ack_err_q <= 1'b1;
              if (err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 8'd1;
            end else begin
              retry_q <= retry_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign i2c_config_index = idx_q;
  assign i2c_config_done  = done_q;
  assign i2c_ack_err      = ack_err_q;
  assign i2c_err_cnt      = err_cnt_q;
  assign i2c_sclk         = scl_q;
  assign i2c_sdat         = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_sc130gs_i2c_cfg_writer.sv
// Bench for sc130gs_i2c_cfg_writer: an I2C slave monitor decodes transfers into a queue
// that each scenario task compares against the writes it expects from its LUT contents.
module tb_sc130gs_i2c_cfg_writer;

  localparam int POWERON_DLY = 20;
  localparam int REG_GAP     = 10;
  localparam int BUDGET      = 8000;

  typedef struct packed {
    logic        nack;
    logic [2:0]  nb;
    logic [31:0] w;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  cfg_index;
  logic [23:0] cfg_data;
  logic [8:0]  cfg_size = '0;
  logic        done, ack_err, scl;
  logic [7:0]  err_cnt;
  wire         sda;
  logic        slave_drv = 1'b0;
  logic [23:0] lut [0:511];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  xfer_t exp_q[$];
  xfer_t obs_q[$];
  int    gap_q[$];

  // slave monitor state
  logic        scl_p = 1'b1, sda_p = 1'b1, sda_s;
  bit          in_xfer = 0, have_stop = 0;
  int          bitn = 0, mon_byten = 0;
  logic [7:0]  sh;
  logic [31:0] w;
  logic        nack_seen;
  int          start_cnt = 0, stop_cnt = 0, stop_cyc = 0, first_start_cyc = -1, scl_edges = 0;
  int          nack_addr_left = 0;
  bit          nack_data_en = 0;
  logic [15:0] nack_data_addr = '0;

  pullup (sda);
  assign sda      = slave_drv ? 1'b0 : 1'bz;
  assign cfg_data = lut[cfg_index];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sc130gs_i2c_cfg_writer #(
    .CLK_FREQ    (800_000),
    .I2C_FREQ    (100_000),
    .I2C_WADDR   (8'h60),
    .POWERON_DLY (POWERON_DLY),
    .REG_GAP     (REG_GAP),
    .RETRY_MAX   (3)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i2c_config_index (cfg_index),
    .i2c_config_data  (cfg_data),
    .i2c_config_size  (cfg_size),
    .i2c_config_done  (done),
    .i2c_ack_err      (ack_err),
    .i2c_err_cnt      (err_cnt),
    .i2c_sclk         (scl),
    .i2c_sdat         (sda)
  );

  always @(negedge clk) begin
    sda_s = (sda === 1'b0) ? 1'b0 : 1'b1;
    if (!rst_n) begin
      in_xfer = 0; bitn = 0; mon_byten = 0; slave_drv = 1'b0; have_stop = 0;
    end else begin
      if (scl != scl_p) scl_edges++;
      if (scl && scl_p && sda_p && !sda_s) begin
        in_xfer = 1; bitn = 0; mon_byten = 0; w = '0; sh = '0; nack_seen = 1'b0;
        start_cnt++;
        if (first_start_cyc < 0) first_start_cyc = cyc;
        if (have_stop) gap_q.push_back(cyc - stop_cyc);
      end else if (scl && scl_p && !sda_p && sda_s) begin
        if (in_xfer) obs_q.push_back({nack_seen, 3'(mon_byten), w});
        in_xfer = 0; stop_cnt++; stop_cyc = cyc; have_stop = 1;
      end else if (in_xfer && scl && !scl_p) begin
        if (bitn < 8) begin
          sh = {sh[6:0], sda_s};
          bitn++;
        end else begin
          w = {w[23:0], sh};
          mon_byten++;
          bitn = 0;
          if (sda_s) begin
            nack_seen = 1'b1;
            if (mon_byten == 1 && nack_addr_left > 0) nack_addr_left--;
          end
        end
      end else if (in_xfer && !scl && scl_p) begin
        if (bitn == 8)
          slave_drv = !((mon_byten == 0 && nack_addr_left > 0) ||
                        (mon_byten == 3 && nack_data_en && w[15:0] == nack_data_addr));
        else
          slave_drv = 1'b0;
      end
    end
    scl_p = scl;
    sda_p = sda_s;
  end

  task automatic do_reset(output int rel_cyc);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs_q.delete(); gap_q.delete();
    start_cnt = 0; stop_cnt = 0; scl_edges = 0; first_start_cyc = -1;
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, output int done_at);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    done_at = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (scl !== 1'b1)     begin n_fail++; $display("FAIL reset_scl: got %b, required 1", scl); end
    n_checks++; if (sda !== 1'b1)     begin n_fail++; $display("FAIL reset_sda: got %b, required released(1)", sda); end
    n_checks++; if (cfg_index !== 0)  begin n_fail++; $display("FAIL reset_index: got %0d, required 0", cfg_index); end
    n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
    n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b, required 0", ack_err); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt); end
  endtask

  task automatic test_single();
    int rel, t;
    xfer_t e, o;
    lut[0] = {16'h3039, 8'hd3};
    cfg_size = 9'd1;
    exp_q.push_back({1'b0, 3'd4, 8'h60, lut[0]});
    do_reset(rel);
    wait_done(BUDGET, t);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b, required 1", done); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL single_xfer: got %h, required %h", o, e); end
    end
    exp_q.delete();
    n_checks++; if (start_cnt != 1 || stop_cnt != 1) begin n_fail++; $display("FAIL single_start_stop: got %0d/%0d, required 1/1", start_cnt, stop_cnt); end
    n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL single_ack_err: got %b, required 0", ack_err); end
    n_checks++; if (cfg_index !== 9'd1) begin n_fail++; $display("FAIL single_index: got %0d, required 1", cfg_index); end
  endtask

  task automatic test_three();
    int rel, t;
    xfer_t e, o;
    lut[0] = {16'h0103, 8'h01};
    lut[1] = {16'h3039, 8'hd3};
    lut[2] = {16'h0100, 8'h01};
    cfg_size = 9'd3;
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 3'd4, 8'h60, lut[i]});
    do_reset(rel);
    wait_done(BUDGET, t);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL three_done: got %b, required 1", done); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL three_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL three_xfer: got %h, required %h", o, e); end
    end
    exp_q.delete();
    n_checks++;
    if (gap_q.size() != 2) begin
      n_fail++; $display("FAIL three_gap_count: got %0d, required 2", gap_q.size());
    end else begin
      if (gap_q[0] < POWERON_DLY || gap_q[0] > POWERON_DLY + 8) begin n_fail++; $display("FAIL three_gap0: got %0d clks, required %0d..%0d", gap_q[0], POWERON_DLY, POWERON_DLY + 8); end
      n_checks++;
      if (gap_q[1] < REG_GAP || gap_q[1] > REG_GAP + 8) begin n_fail++; $display("FAIL three_gap1: got %0d clks, required %0d..%0d", gap_q[1], REG_GAP, REG_GAP + 8); end
    end
    n_checks++; if (t - stop_cyc < REG_GAP || t - stop_cyc > REG_GAP + 6) begin n_fail++; $display("FAIL three_done_delay: got %0d clks, required %0d..%0d", t - stop_cyc, REG_GAP, REG_GAP + 6); end
    n_checks++; if (cfg_index !== 9'd3) begin n_fail++; $display("FAIL three_index: got %0d, required 3", cfg_index); end
  endtask

  task automatic test_nack_retry();
    int rel, t;
    xfer_t e, o;
    lut[0] = {16'h3e01, 8'h22};
    cfg_size = 9'd1;
    nack_addr_left = 2;
    exp_q.push_back({1'b1, 3'd1, 32'h0000_0060});
    exp_q.push_back({1'b1, 3'd1, 32'h0000_0060});
    exp_q.push_back({1'b0, 3'd4, 8'h60, lut[0]});
    do_reset(rel);
    wait_done(BUDGET, t);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL retry_done: got %b, required 1", done); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL retry_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL retry_xfer: got %h, required %h", o, e); end
    end
    exp_q.delete();
    n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL retry_ack_err: got %b, required 0", ack_err); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL retry_err_cnt: got %0d, required 0", err_cnt); end
    n_checks++; if (cfg_index !== 9'd1) begin n_fail++; $display("FAIL retry_index: got %0d, required 1", cfg_index); end
    nack_addr_left = 0;
  endtask

  task automatic test_nack_skip();
    int rel, t;
    xfer_t e, o;
    lut[0] = {16'h3e01, 8'h55};
    lut[1] = {16'h0100, 8'h01};
    cfg_size = 9'd2;
    nack_data_en = 1; nack_data_addr = 16'h3e01;
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 3'd4, 8'h60, lut[0]});
    exp_q.push_back({1'b0, 3'd4, 8'h60, lut[1]});
    do_reset(rel);
    wait_done(BUDGET, t);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL skip_done: got %b, required 1", done); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL skip_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL skip_xfer: got %h, required %h", o, e); end
    end
    exp_q.delete();
    n_checks++; if (ack_err !== 1'b1) begin n_fail++; $display("FAIL skip_ack_err: got %b, required 1", ack_err); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL skip_err_cnt: got %0d, required 1", err_cnt); end
    n_checks++; if (cfg_index !== 9'd2) begin n_fail++; $display("FAIL skip_index: got %0d, required 2", cfg_index); end
    nack_data_en = 0;
  endtask

  task automatic test_size_zero();
    int rel, t;
    cfg_size = 9'd0;
    do_reset(rel);
    wait_done(BUDGET, t);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b, required 1", done); end
    n_checks++; if (t - rel < POWERON_DLY || t - rel > POWERON_DLY + 4) begin n_fail++; $display("FAIL zero_done_time: got %0d clks, required %0d..%0d", t - rel, POWERON_DLY, POWERON_DLY + 4); end
    n_checks++; if (scl_edges != 0) begin n_fail++; $display("FAIL zero_scl_edges: got %0d, required 0", scl_edges); end
    n_checks++; if (cfg_index !== 9'd0) begin n_fail++; $display("FAIL zero_index: got %0d, required 0", cfg_index); end
  endtask

  task automatic test_reset_mid();
    int rel, t, n;
    xfer_t e, o;
    lut[0] = {16'h0103, 8'h01};
    lut[1] = {16'h3039, 8'hd3};
    lut[2] = {16'h0100, 8'h01};
    cfg_size = 9'd3;
    do_reset(rel);
    n = 0;
    while (!(start_cnt == 3 && mon_byten >= 1) && n < BUDGET) begin
      @(negedge clk); n++;
    end
    n_checks++; if (start_cnt != 3 || mon_byten < 1) begin n_fail++; $display("FAIL mid_reach_entry2: got starts=%0d bytes=%0d, required 3/>=1", start_cnt, mon_byten); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (scl !== 1'b1)    begin n_fail++; $display("FAIL mid_scl: got %b, required 1", scl); end
    n_checks++; if (sda !== 1'b1)    begin n_fail++; $display("FAIL mid_sda: got %b, required released(1)", sda); end
    n_checks++; if (cfg_index !== 0) begin n_fail++; $display("FAIL mid_index: got %0d, required 0", cfg_index); end
    n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL mid_done: got %b, required 0", done); end
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 3'd4, 8'h60, lut[i]});
    do_reset(rel);
    wait_done(BUDGET, t);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mid_restart_done: got %b, required 1", done); end
    n_checks++; if (first_start_cyc - rel < POWERON_DLY || first_start_cyc - rel > POWERON_DLY + 8) begin n_fail++; $display("FAIL mid_first_start: got %0d clks, required %0d..%0d", first_start_cyc - rel, POWERON_DLY, POWERON_DLY + 8); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL mid_xfer: got %h, required %h", o, e); end
    end
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) lut[i] = '0;
    test_reset();
    test_single();
    test_three();
    test_nack_retry();
    test_nack_skip();
    test_size_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
